router_reg: RTL and testbench
=============================

ROUTER_REG -- requirements
Module: router_reg

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, giving the byte width of data_in and dout.
REQ-002 SHALL have port clock, input, 1, the single rising-edge clock for all state.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port pkt_valid, input, 1, source byte valid; it deasserts on the parity byte.
REQ-005 SHALL have port data_in, input, DATA_WIDTH, source byte: header, payload or parity.
REQ-006 SHALL have port fifo_full, input, 1, the selected destination FIFO is full.
REQ-007 SHALL have ports detect_add, lfd_state, ld_state, full_state, laf_state, rst_int_reg, each input, 1, one-hot state decodes from the router FSM.
REQ-008 SHALL have port dout, output, DATA_WIDTH, the byte presented to the FIFO write port.
REQ-009 SHALL have ports parity_done and low_pkt_valid, each output, 1, status returned to the FSM.
REQ-010 SHALL have port err, output, 1, parity mismatch flag for the current packet.

Function
REQ-011 SHALL latch header_byte <= data_in when detect_add && pkt_valid, and hold it otherwise.
REQ-012 SHALL drive dout <= header_byte on the cycle after lfd_state.
REQ-013 SHALL drive dout <= data_in when ld_state && !fifo_full.
REQ-014 SHALL capture full_byte <= data_in when ld_state && fifo_full, and leave dout unchanged on that cycle.
REQ-015 SHALL drive dout <= full_byte when laf_state, then hold dout in every other case.
REQ-016 SHALL keep int_parity as follows: cleared on detect_add; loaded with header_byte on lfd_state; XORed with data_in when ld_state && pkt_valid && !full_state.
REQ-017 SHALL latch pkt_parity <= data_in when ld_state && !pkt_valid && !fifo_full.
REQ-018 SHALL set parity_done in two cases: (a) ld_state && !fifo_full && !pkt_valid; (b) laf_state && low_pkt_valid && !parity_done.
REQ-019 SHALL clear parity_done on detect_add; detect_add wins over any simultaneous set condition.
REQ-020 SHALL set low_pkt_valid when ld_state && !pkt_valid, clear it when rst_int_reg is high, and give rst_int_reg priority over the set.
REQ-021 SHALL update err <= (int_parity != pkt_parity) on each cycle where parity_done is 1, clear err on detect_add, and hold err otherwise.
REQ-022 SHALL make err valid two cycles after the parity byte is accepted.
REQ-023 SHALL ignore the fifo_full input during lfd_state and laf_state.
REQ-024 SHALL, when two one-hot state inputs are asserted illegally, give priority detect_add > lfd_state > ld_state > laf_state.

Reset
REQ-025 SHALL, on asynchronous assertion of reset, immediately clear dout, header_byte, full_byte, int_parity, pkt_parity, parity_done, low_pkt_valid and err to 0.
REQ-026 SHALL, when reset asserts mid-packet, abandon the packet without emitting any partial status.
REQ-027 SHALL release reset synchronously to clock, and make the first packet after release behave identically to a packet after power-up.

Configuration
REQ-028 SHALL, with macro ROUTER_REG_LEN_CHECK_EN defined, add output len_err (1 bit) and an internal 6-bit counter with the following behaviour.
REQ-029 SHALL, with ROUTER_REG_LEN_CHECK_EN defined, clear the counter on detect_add, increment it on each payload byte accepted per REQ-016, and set len_err with parity_done when counter != header_byte[7:2].
REQ-030 SHALL, with ROUTER_REG_LEN_CHECK_EN defined, clear len_err on detect_add and on reset.
REQ-031 SHALL, without ROUTER_REG_LEN_CHECK_EN, have no len_err port and no counter; all other behaviour SHALL be identical to the macro-defined build.

Structure
REQ-032 SHALL take the following from shared package router_pkg: DATA_WIDTH default, header field constants ADDR_LSB=0, ADDR_MSB=1, LEN_LSB=2, LEN_MSB=7, and the 2-bit port address typedef.
REQ-033 SHALL instantiate one sub-module, router_parity_acc, holding int_parity (clear/load/xor controls); all other logic stays flat in router_reg.

Verification
REQ-034 SHALL cover a good packet: header 0x0D, payload 0x11,0x22,0x33, parity 0x0D, no fifo_full -> dout sequence 0x0D,0x11,0x22,0x33,0x0D; parity_done=1; err=0.
REQ-035 SHALL cover a bad parity: same packet with parity byte 0x0C -> err=1 two cycles after the parity byte, err cleared on the next detect_add.
REQ-036 SHALL cover full mid-packet: fifo_full high while 0x22 arrives in ld_state, then full_state, then laf_state -> full_byte=0x22, dout=0x22 in laf, no byte lost or duplicated.
REQ-037 SHALL cover the late parity path: low_pkt_valid=1 with parity pending, laf_state -> parity_done set exactly once; rst_int_reg then clears low_pkt_valid.
REQ-038 SHALL cover reset mid-payload: reset pulsed after 0x11 -> all outputs 0 immediately; next packet 0x05,0xAA,parity 0xAF -> err=0.
REQ-039 SHALL cover the length check with ROUTER_REG_LEN_CHECK_EN defined: header 0x0D (length 3) with 2 payload bytes -> len_err=1; with 3 payload bytes -> len_err=0.

Source files
------------

// File: rtl/router_pkg.sv
// Shared router definitions: default byte width, header field positions
// and the destination port address type.
package router_pkg;

  localparam int ROUTER_DATA_WIDTH = 8;

  // Header byte layout: {length[5:0], port_addr[1:0]}
  localparam int ADDR_LSB  = 0;
  localparam int ADDR_MSB  = 1;
  localparam int LEN_LSB   = 2;
  localparam int LEN_MSB   = 7;
  localparam int LEN_WIDTH = LEN_MSB - LEN_LSB + 1;

  typedef logic [ADDR_MSB-ADDR_LSB:0] port_addr_t;

endpackage

// File: rtl/router_parity_acc.sv
// Running XOR parity over the header and payload bytes of one packet.
module router_parity_acc
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = ROUTER_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_value,
  input  logic                  xor_en,
  input  logic [DATA_WIDTH-1:0] xor_value,
  output logic [DATA_WIDTH-1:0] parity
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)       parity <= '0;
    else if (clear)  parity <= '0;
    else if (load)   parity <= load_value;
    else if (xor_en) parity <= parity ^ xor_value;
  end

endmodule

// File: rtl/router_reg.sv
// Router datapath register: header/full-byte holding, FIFO write data and parity status.
// Optional packet length check (len_err) is enabled by defining ROUTER_REG_LEN_CHECK_EN.
module router_reg
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = ROUTER_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  pkt_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  fifo_full,
  input  logic                  detect_add,
  input  logic                  lfd_state,
  input  logic                  ld_state,
  input  logic                  full_state,
  input  logic                  laf_state,
  input  logic                  rst_int_reg,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  parity_done,
  output logic                  low_pkt_valid,
  output logic                  err
`ifdef ROUTER_REG_LEN_CHECK_EN
  ,
  output logic                  len_err
`endif
);

  logic [DATA_WIDTH-1:0] header_byte;
  logic [DATA_WIDTH-1:0] full_byte;
  logic [DATA_WIDTH-1:0] pkt_parity;
  logic [DATA_WIDTH-1:0] int_parity;

  // Resolve illegal multi-hot state inputs: detect_add > lfd > ld > laf.
  logic do_lfd, do_ld, do_laf;
  assign do_lfd = lfd_state & ~detect_add;
  assign do_ld  = ld_state  & ~detect_add & ~lfd_state;
  assign do_laf = laf_state & ~detect_add & ~lfd_state & ~ld_state;

  logic payload_acc, parity_accept, late_parity, parity_done_set;
  assign payload_acc     = do_ld & pkt_valid & ~full_state;
  assign parity_accept   = do_ld & ~pkt_valid & ~fifo_full;
  assign late_parity     = do_laf & low_pkt_valid & ~parity_done;
  assign parity_done_set = parity_accept | late_parity;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                         header_byte <= '0;
    else if (detect_add && pkt_valid)  header_byte <= data_in;
  end

  // A byte arriving while the FIFO is full is parked and replayed in laf_state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dout      <= '0;
      full_byte <= '0;
    end else if (detect_add) begin
      dout <= dout;
    end else if (do_lfd) begin
      dout <= header_byte;
    end else if (do_ld) begin
      if (fifo_full) full_byte <= data_in;
      else           dout      <= data_in;
    end else if (do_laf) begin
      dout <= full_byte;
    end
  end

  router_parity_acc #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_parity_acc (
    .clock     (clock),
    .reset     (reset),
    .clear     (detect_add),
    .load      (do_lfd),
    .load_value(header_byte),
    .xor_en    (payload_acc),
    .xor_value (data_in),
    .parity    (int_parity)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset)              pkt_parity <= '0;
    else if (parity_accept) pkt_parity <= data_in;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                parity_done <= 1'b0;
    else if (detect_add)      parity_done <= 1'b0;
    else if (parity_done_set) parity_done <= 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                      low_pkt_valid <= 1'b0;
    else if (rst_int_reg)           low_pkt_valid <= 1'b0;
    else if (do_ld && !pkt_valid)   low_pkt_valid <= 1'b1;
  end

  // err trails parity_done by one cycle so both parity operands have settled.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)            err <= 1'b0;
    else if (detect_add)  err <= 1'b0;
    else if (parity_done) err <= (int_parity != pkt_parity);
  end

`ifdef ROUTER_REG_LEN_CHECK_EN
  logic [LEN_WIDTH-1:0] payload_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)            payload_count <= '0;
    else if (detect_add)  payload_count <= '0;
    else if (payload_acc) payload_count <= payload_count + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                len_err <= 1'b0;
    else if (detect_add)      len_err <= 1'b0;
    else if (parity_done_set) len_err <= (payload_count != header_byte[LEN_MSB:LEN_LSB]);
  end
`endif

endmodule

// File: tb/tb_router_reg.sv
// Directed-vector bench for router_reg; covers the length check when
// ROUTER_REG_LEN_CHECK_EN is defined.
module tb_router_reg;

  logic       clock = 1'b0;
  logic       reset;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic       fifo_full;
  logic       detect_add, lfd_state, ld_state, full_state, laf_state, rst_int_reg;
  logic [7:0] dout;
  logic       parity_done, low_pkt_valid, err;
`ifdef ROUTER_REG_LEN_CHECK_EN
  logic       len_err;
`endif

  int check_count = 0;
  int fail_count  = 0;

  // State vector bit order: {rst_int_reg, laf, full, ld, lfd, detect_add}
  localparam logic [5:0] ST_NONE = 6'b000000;
  localparam logic [5:0] ST_DA   = 6'b000001;
  localparam logic [5:0] ST_LFD  = 6'b000010;
  localparam logic [5:0] ST_LD   = 6'b000100;
  localparam logic [5:0] ST_FULL = 6'b001000;
  localparam logic [5:0] ST_LAF  = 6'b010000;
  localparam logic [5:0] ST_RIR  = 6'b100000;

  router_reg #(.DATA_WIDTH(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .pkt_valid    (pkt_valid),
    .data_in      (data_in),
    .fifo_full    (fifo_full),
    .detect_add   (detect_add),
    .lfd_state    (lfd_state),
    .ld_state     (ld_state),
    .full_state   (full_state),
    .laf_state    (laf_state),
    .rst_int_reg  (rst_int_reg),
    .dout         (dout),
    .parity_done  (parity_done),
    .low_pkt_valid(low_pkt_valid),
    .err          (err)
`ifdef ROUTER_REG_LEN_CHECK_EN
    ,
    .len_err      (len_err)
`endif
  );

  always #5 clock = ~clock;

  task automatic applyStimulus(input logic [5:0] st, input logic pv, input logic ff,
                               input logic [7:0] d);
    {rst_int_reg, laf_state, full_state, ld_state, lfd_state, detect_add} = st;
    pkt_valid = pv;
    fifo_full = ff;
    data_in   = d;
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] actual,
                             input logic [7:0] expected);
    check_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  initial begin
    reset = 1'b1;
    {rst_int_reg, laf_state, full_state, ld_state, lfd_state, detect_add} = ST_NONE;
    pkt_valid = 1'b0;
    fifo_full = 1'b0;
    data_in   = 8'h00;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    checkOutput("reset_dout", dout, 8'h00);
    checkOutput("reset_parity_done", parity_done, 1'b0);
    checkOutput("reset_low_pkt_valid", low_pkt_valid, 1'b0);
    checkOutput("reset_err", err, 1'b0);

    // Good packet: 0D, 11, 22, 33, parity 0D
    $display("[TB] good packet");
    applyStimulus(ST_DA, 1, 0, 8'h0D);
    checkOutput("good_da_parity_done", parity_done, 1'b0);
    applyStimulus(ST_LFD, 1, 0, 8'h0D);
    checkOutput("good_dout_hdr", dout, 8'h0D);
    applyStimulus(ST_LD, 1, 0, 8'h11);
    checkOutput("good_dout_11", dout, 8'h11);
    applyStimulus(ST_LD, 1, 0, 8'h22);
    checkOutput("good_dout_22", dout, 8'h22);
    applyStimulus(ST_LD, 1, 0, 8'h33);
    checkOutput("good_dout_33", dout, 8'h33);
    applyStimulus(ST_LD, 0, 0, 8'h0D);
    checkOutput("good_dout_par", dout, 8'h0D);
    checkOutput("good_parity_done", parity_done, 1'b1);
    checkOutput("good_low_pkt_valid", low_pkt_valid, 1'b1);
    applyStimulus(ST_NONE, 0, 0, 8'h00);
    checkOutput("good_err", err, 1'b0);
    applyStimulus(ST_RIR, 0, 0, 8'h00);
    checkOutput("good_rir_lpv", low_pkt_valid, 1'b0);

    // Bad parity: same packet, parity byte 0C
    $display("[TB] bad parity");
    applyStimulus(ST_DA, 1, 0, 8'h0D);
    checkOutput("bad_da_parity_done", parity_done, 1'b0);
    applyStimulus(ST_LFD, 1, 0, 8'h0D);
    applyStimulus(ST_LD, 1, 0, 8'h11);
    applyStimulus(ST_LD, 1, 0, 8'h22);
    applyStimulus(ST_LD, 1, 0, 8'h33);
    applyStimulus(ST_LD, 0, 0, 8'h0C);
    checkOutput("bad_dout_par", dout, 8'h0C);
    checkOutput("bad_err_early", err, 1'b0);
    applyStimulus(ST_NONE, 0, 0, 8'h00);
    checkOutput("bad_err_set", err, 1'b1);
    applyStimulus(ST_RIR, 0, 0, 8'h00);
    checkOutput("bad_err_hold", err, 1'b1);
    checkOutput("bad_rir_lpv", low_pkt_valid, 1'b0);

    // Full mid-packet: 22 parked in full_byte, replayed in laf
    $display("[TB] fifo full mid-packet");
    applyStimulus(ST_DA, 1, 0, 8'h0D);
    checkOutput("bad_err_cleared", err, 1'b0);
    applyStimulus(ST_LFD, 1, 1, 8'h0D);
    checkOutput("full_dout_hdr", dout, 8'h0D);
    applyStimulus(ST_LD, 1, 0, 8'h11);
    checkOutput("full_dout_11", dout, 8'h11);
    applyStimulus(ST_LD, 1, 1, 8'h22);
    checkOutput("full_dout_hold_ld", dout, 8'h11);
    applyStimulus(ST_FULL, 1, 1, 8'h22);
    checkOutput("full_dout_hold_full", dout, 8'h11);
    applyStimulus(ST_LAF, 1, 1, 8'h22);
    checkOutput("full_dout_laf", dout, 8'h22);
    checkOutput("full_laf_parity_done", parity_done, 1'b0);
    applyStimulus(ST_LD, 1, 0, 8'h33);
    checkOutput("full_dout_33", dout, 8'h33);
    applyStimulus(ST_LD, 0, 0, 8'h0D);
    checkOutput("full_parity_done", parity_done, 1'b1);
    applyStimulus(ST_NONE, 0, 0, 8'h00);
    checkOutput("full_err", err, 1'b0);
    applyStimulus(ST_RIR, 0, 0, 8'h00);

    // Late parity: parity byte arrives with FIFO full, completes in laf
    $display("[TB] late parity");
    applyStimulus(ST_DA, 1, 0, 8'h04);
    applyStimulus(ST_LFD, 1, 0, 8'h04);
    checkOutput("late_dout_hdr", dout, 8'h04);
    applyStimulus(ST_LD, 1, 0, 8'hAB);
    checkOutput("late_dout_ab", dout, 8'hAB);
    applyStimulus(ST_LD, 0, 1, 8'hAF);
    checkOutput("late_dout_hold", dout, 8'hAB);
    checkOutput("late_lpv_set", low_pkt_valid, 1'b1);
    checkOutput("late_pd_pending", parity_done, 1'b0);
    applyStimulus(ST_FULL, 0, 1, 8'hAF);
    checkOutput("late_pd_full", parity_done, 1'b0);
    applyStimulus(ST_LAF, 0, 0, 8'hAF);
    checkOutput("late_dout_laf", dout, 8'hAF);
    checkOutput("late_pd_set", parity_done, 1'b1);
    applyStimulus(ST_LAF, 0, 0, 8'hAF);
    checkOutput("late_pd_stays", parity_done, 1'b1);
    applyStimulus(ST_RIR, 0, 0, 8'h00);
    checkOutput("late_rir_lpv", low_pkt_valid, 1'b0);

    // Reset mid-payload, then a fresh packet 05, AA, parity AF
    $display("[TB] reset mid-payload");
    applyStimulus(ST_DA, 1, 0, 8'h0D);
    applyStimulus(ST_LFD, 1, 0, 8'h0D);
    applyStimulus(ST_LD, 1, 0, 8'h11);
    checkOutput("rst_dout_before", dout, 8'h11);
    {rst_int_reg, laf_state, full_state, ld_state, lfd_state, detect_add} = ST_NONE;
    pkt_valid = 1'b0;
    reset = 1'b1;
    #1;
    checkOutput("rst_async_dout", dout, 8'h00);
    checkOutput("rst_async_pd", parity_done, 1'b0);
    checkOutput("rst_async_lpv", low_pkt_valid, 1'b0);
    checkOutput("rst_async_err", err, 1'b0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    applyStimulus(ST_DA, 1, 0, 8'h05);
    applyStimulus(ST_LFD, 1, 0, 8'h05);
    checkOutput("post_rst_dout_hdr", dout, 8'h05);
    applyStimulus(ST_LD, 1, 0, 8'hAA);
    checkOutput("post_rst_dout_aa", dout, 8'hAA);
    applyStimulus(ST_LD, 0, 0, 8'hAF);
    checkOutput("post_rst_pd", parity_done, 1'b1);
    applyStimulus(ST_NONE, 0, 0, 8'h00);
    checkOutput("post_rst_err", err, 1'b0);

    // Illegal multi-hot state inputs resolve by priority
    $display("[TB] state priority");
    applyStimulus(ST_DA | ST_LFD, 1, 0, 8'h0D);
    checkOutput("prio_da_dout_hold", dout, 8'hAF);
    checkOutput("prio_da_pd_clear", parity_done, 1'b0);
    applyStimulus(ST_LFD, 1, 0, 8'h0D);
    checkOutput("prio_lfd_dout", dout, 8'h0D);
    applyStimulus(ST_LFD | ST_LD, 1, 0, 8'h77);
    checkOutput("prio_lfd_over_ld", dout, 8'h0D);
    applyStimulus(ST_LD | ST_LAF, 1, 0, 8'h12);
    checkOutput("prio_ld_over_laf", dout, 8'h12);

`ifdef ROUTER_REG_LEN_CHECK_EN
    // Header 0D declares 3 payload bytes
    $display("[TB] length check");
    applyStimulus(ST_DA, 1, 0, 8'h0D);
    applyStimulus(ST_LFD, 1, 0, 8'h0D);
    applyStimulus(ST_LD, 1, 0, 8'h11);
    applyStimulus(ST_LD, 1, 0, 8'h22);
    applyStimulus(ST_LD, 0, 0, 8'h3E);
    checkOutput("len_short_pd", parity_done, 1'b1);
    checkOutput("len_short_err", len_err, 1'b1);
    applyStimulus(ST_NONE, 0, 0, 8'h00);
    checkOutput("len_short_parity_err", err, 1'b0);
    applyStimulus(ST_DA, 1, 0, 8'h0D);
    checkOutput("len_err_cleared", len_err, 1'b0);
    applyStimulus(ST_LFD, 1, 0, 8'h0D);
    applyStimulus(ST_LD, 1, 0, 8'h11);
    applyStimulus(ST_LD, 1, 0, 8'h22);
    applyStimulus(ST_LD, 1, 0, 8'h33);
    applyStimulus(ST_LD, 0, 0, 8'h0D);
    checkOutput("len_ok_pd", parity_done, 1'b1);
    checkOutput("len_ok_err", len_err, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
    $finish;
  end

endmodule
